// File: rtl/addr_word_ctr.sv
`default_nettype none
// ============================================================================
//  Module      : addr_word_ctr
//  Description : Parametrised address / word-count generator. Holds an address
//                counter and a word counter, each with a backup register for
//                reinitialisation. Either pair loads from a shared 2:1 source
//                mux. A step moves the address up or down by one and counts
//                the word counter down toward zero. The block flags completion
//                (word count zero) and address wrap-around.
//  Revision    : 1.0  initial release
// ----------------------------------------------------------------------------
//  Parameters
//    WIDTH     bit width of data ports, counters and backups (>= 2)
//  Ports
//    clk       system clock, all state updates on posedge
//    rst       asynchronous active-high reset
//    di_a      load source A
//    di_b      load source B
//    sel       source select (0 = di_a, 1 = di_b)
//    ld_addr   load address backup and counter from the selected source
//    ld_wc     load word-count backup and counter from the selected source
//    reinit    copy backups into the counters (pairs not being loaded)
//    step      advance one transfer
//    dir       address direction (0 = increment, 1 = decrement)
//    addr_out  address counter value
//    wc_out    word counter value
//    done      word counter is zero (registered)
//    wrap      one-cycle pulse after a step that wrapped the address
// ============================================================================
module addr_word_ctr #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] di_a,
    input  logic [WIDTH-1:0] di_b,
    input  logic             sel,
    input  logic             ld_addr,
    input  logic             ld_wc,
    input  logic             reinit,
    input  logic             step,
    input  logic             dir,
    output logic [WIDTH-1:0] addr_out,
    output logic [WIDTH-1:0] wc_out,
    output logic             done,
    output logic             wrap
);

    // ------------------------------------------------------------------------
    // Constants
    // ------------------------------------------------------------------------
    localparam logic [WIDTH-1:0] c_ZERO = '0;
    localparam logic [WIDTH-1:0] c_ONE  = {{(WIDTH-1){1'b0}}, 1'b1};
    localparam logic [WIDTH-1:0] c_ALL1 = '1;

    // ------------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------------
    logic [WIDTH-1:0] r_addr_bk;
    logic [WIDTH-1:0] r_addr;
    logic [WIDTH-1:0] r_wc_bk;
    logic [WIDTH-1:0] r_wc;
    logic             r_done;
    logic             r_wrap;

    // ------------------------------------------------------------------------
    // Combinational datapath
    // ------------------------------------------------------------------------
    logic [WIDTH-1:0] w_src;
    logic             w_wc_zero;
    logic             w_step_req;
    logic             w_step_take;
    logic [WIDTH-1:0] w_addr_stepped;
    logic             w_wrap_up;
    logic             w_wrap_dn;
    logic             w_wrap_nxt;
    logic [WIDTH-1:0] w_addr_nxt;
    logic [WIDTH-1:0] w_wc_nxt;

    // Shared source mux: simultaneous loads of both pairs see the same value.
    assign w_src = sel ? di_b : di_a;

    assign w_wc_zero = (r_wc == c_ZERO);

    // A step request is only honoured in a cycle with no load or reinit
    // activity on either pair, and only while words remain.
    assign w_step_req  = step & ~ld_addr & ~ld_wc & ~reinit;
    assign w_step_take = w_step_req & ~w_wc_zero;

    // Modulo-2^WIDTH address arithmetic; the truncation is the wrap.
    assign w_addr_stepped = dir ? (r_addr - c_ONE) : (r_addr + c_ONE);

    // Wrap is detected from the pre-step address so no carry chain is needed.
    assign w_wrap_up  = ~dir & (r_addr == c_ALL1);
    assign w_wrap_dn  =  dir & (r_addr == c_ZERO);
    assign w_wrap_nxt = w_step_take & (w_wrap_up | w_wrap_dn);

    // Address counter next value: load > reinit > step > hold.
    always_comb begin
        w_addr_nxt = r_addr;
        if (ld_addr) begin
            w_addr_nxt = w_src;
        end else if (reinit) begin
            w_addr_nxt = r_addr_bk;
        end else if (w_step_take) begin
            w_addr_nxt = w_addr_stepped;
        end
    end

    // Word counter next value: load > reinit > step > hold.
    always_comb begin
        w_wc_nxt = r_wc;
        if (ld_wc) begin
            w_wc_nxt = w_src;
        end else if (reinit) begin
            w_wc_nxt = r_wc_bk;
        end else if (w_step_take) begin
            w_wc_nxt = r_wc - c_ONE;
        end
    end

    // ------------------------------------------------------------------------
    // Backup registers: written only by their own load strobe.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_addr_bk <= c_ZERO;
        end else if (ld_addr) begin
            r_addr_bk <= w_src;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wc_bk <= c_ZERO;
        end else if (ld_wc) begin
            r_wc_bk <= w_src;
        end
    end

    // ------------------------------------------------------------------------
    // Counters
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_addr <= c_ZERO;
            r_wc   <= c_ZERO;
        end else begin
            r_addr <= w_addr_nxt;
            r_wc   <= w_wc_nxt;
        end
    end

    // ------------------------------------------------------------------------
    // Status flags. done tracks the counter value written on the same edge,
    // so it is computed from the next-state word count rather than r_wc.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_done <= 1'b1;
            r_wrap <= 1'b0;
        end else begin
            r_done <= (w_wc_nxt == c_ZERO);
            r_wrap <= w_wrap_nxt;
        end
    end

    // ------------------------------------------------------------------------
    // Outputs: all straight from registers.
    // ------------------------------------------------------------------------
    assign addr_out = r_addr;
    assign wc_out   = r_wc;
    assign done     = r_done;
    assign wrap     = r_wrap;

endmodule

`default_nettype wire
